// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector. The prefix-match state advances through a
// transition table built at elaboration from PATTERN (KMP-style longest border search).
module seq_detect_param #(
  parameter int N       = 4,
  parameter     PATTERN = 4'b1011,
  parameter int OVERLAP = 1,
  parameter int MOORE   = 0,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x,
  input  logic                 en,
  output logic                 z,
  output logic [CNT_W-1:0]     match_count,
  output logic [$clog2(N)-1:0] dbg_s
);

  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("seq_detect_param: N must be in 2..16");
  end
  if ($bits(PATTERN) != N) begin : g_bad_pattern
    $error("seq_detect_param: PATTERN width must equal N");
  end

  // Longest k (k <= s+1, k < N) such that the last k bits of (prefix(s), b) equal
  // the first k pattern bits. Covers advance, fallback and the post-match border.
  function automatic int calc_next(input int s, input int b);
    int res;
    bit ok;
    bit tb;
    res = 0;
    for (int k = 1; k <= N - 1; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          int j;
          j  = s + 1 - k + i;
          tb = (j == s) ? (b != 0) : PATTERN[N-1-j];
          if (tb != PATTERN[N-1-i]) ok = 1'b0;
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

  logic [2*N*SW-1:0] tab;

  for (genvar gs = 0; gs < N; gs++) begin : g_row
    for (genvar gb = 0; gb < 2; gb++) begin : g_col
      localparam int NS = calc_next(gs, gb);
      assign tab[(gs*2+gb)*SW +: SW] = SW'(NS);
    end
  end

  logic [SW-1:0]    s, s_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             match_now;
  int               idx;

  always_comb begin
    match_now = en && (s == LAST) && (x == PATTERN[0]);
    idx       = int'(s) * 2 + int'(x);
    s_nxt     = s;
    cnt_nxt   = match_count;
    if (en) begin
      if (match_now && OVERLAP == 0) s_nxt = '0;
      else                           s_nxt = tab[idx*SW +: SW];
    end
    // Saturate rather than wrap so a long-running stream never reads as few matches.
    if (match_now && match_count != {CNT_W{1'b1}}) cnt_nxt = match_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s           <= '0;
      match_count <= '0;
    end else begin
      s           <= s_nxt;
      match_count <= cnt_nxt;
    end
  end

  if (MOORE != 0) begin : g_moore
    logic z_q;
    always_ff @(posedge clk) begin
      if (reset) z_q <= 1'b0;
      else       z_q <= match_now;
    end
    assign z = z_q;
  end else begin : g_mealy
    assign z = match_now;
  end

  assign dbg_s = s;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four configurations share one stimulus stream and are
// checked every cycle against a history-based model plus hand-computed literals.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic reset, x, en;

  logic       z0, z1, z2, z3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;
  logic [1:0] s0, s1, s2, s3;

  // u0: 1011 overlap Mealy; u1: non-overlap; u2: Moore; u3: 111, 2-bit counter
  seq_detect_param u0 (.clk(clk), .reset(reset), .x(x), .en(en), .z(z0), .match_count(c0), .dbg_s(s0));
  seq_detect_param #(.OVERLAP(0)) u1 (.clk(clk), .reset(reset), .x(x), .en(en), .z(z1), .match_count(c1), .dbg_s(s1));
  seq_detect_param #(.MOORE(1)) u2 (.clk(clk), .reset(reset), .x(x), .en(en), .z(z2), .match_count(c2), .dbg_s(s2));
  seq_detect_param #(.N(3), .PATTERN(3'b111), .CNT_W(2)) u3 (.clk(clk), .reset(reset), .x(x), .en(en), .z(z3), .match_count(c3), .dbg_s(s3));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int          n_a[4]    = '{4, 4, 4, 3};
  logic [15:0] pat_a[4]  = '{16'b1011, 16'b1011, 16'b1011, 16'b111};
  bit          ov_a[4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit          moore_a[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int          cmax_a[4] = '{255, 255, 255, 3};

  // Model state: accepted-bit history (bit 0 newest), its valid length, count, Moore flag
  logic [31:0] hv[4];
  int          hl[4];
  int          mcnt[4];
  bit          mz[4];

  logic        zd[4];
  logic [31:0] cd[4];
  logic [31:0] sd[4];
  assign zd[0] = z0;  assign zd[1] = z1;  assign zd[2] = z2;  assign zd[3] = z3;
  assign cd[0] = 32'(c0); assign cd[1] = 32'(c1); assign cd[2] = 32'(c2); assign cd[3] = 32'(c3);
  assign sd[0] = 32'(s0); assign sd[1] = 32'(s1); assign sd[2] = 32'(s2); assign sd[3] = 32'(s3);

  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Longest k <= maxk whose last k history bits equal the first k pattern bits.
  function automatic int lps(input logic [31:0] h, input int hlen, input int n,
                             input logic [15:0] pat, input int maxk);
    int best;
    best = 0;
    for (int k = 1; k <= maxk; k++) begin
      bit ok;
      ok = (k <= hlen);
      for (int i = 0; i < k; i++)
        if (h[k-1-i] !== pat[n-1-i]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  function automatic bit completes(input int i, input logic xb);
    logic [31:0] h2;
    h2 = {hv[i][30:0], xb};
    return lps(h2, hl[i] + 1, n_a[i], pat_a[i], n_a[i]) == n_a[i];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        hl[i] = 0; hv[i] = '0; mcnt[i] = 0; mz[i] = 1'b0;
      end else begin
        bit mn;
        mn = en && completes(i, x);
        mz[i] = mn;
        if (en) begin
          hv[i] = {hv[i][30:0], x};
          hl[i] = (hl[i] < 31) ? hl[i] + 1 : 31;
        end
        if (mn) begin
          if (mcnt[i] < cmax_a[i]) mcnt[i]++;
          if (!ov_a[i]) hl[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        logic ez;
        ez = moore_a[i] ? mz[i] : (en && completes(i, x));
        check($sformatf("model_z[%0d]", i), 32'(zd[i]), 32'(ez));
        check($sformatf("model_count[%0d]", i), cd[i], 32'(mcnt[i]));
        check($sformatf("model_s[%0d]", i), sd[i], 32'(lps(hv[i], hl[i], n_a[i], pat_a[i], n_a[i] - 1)));
      end
    end
  end

  task automatic drive(input logic xv, input logic ev, input logic rv);
    x = xv; en = ev; reset = rv;
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seq1[10] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
  int lit0[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
  int lit1[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  int lit2[10] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0};

  initial begin
    reset = 1'b1; x = 1'b0; en = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    drive(0, 0, 1);
    check("reset_z0", 32'(z0), 0);
    check("reset_z2", 32'(z2), 0);
    check("reset_count0", cd[0], 0);
    tick();

    // 1011011011 on all instances
    for (int k = 0; k < 10; k++) exp_q.push_back(1'(lit0[k]));
    for (int k = 0; k < 10; k++) begin
      logic [0:0] e0;
      drive(1'(seq1[k]), 1, 0);
      e0 = exp_q.pop_front();
      check($sformatf("lit_ov_z bit%0d", k + 1), 32'(z0), 32'(e0));
      check($sformatf("lit_nov_z bit%0d", k + 1), 32'(z1), 32'(lit1[k]));
      check($sformatf("lit_moore_z bit%0d", k + 1), 32'(z2), 32'(lit2[k]));
      tick();
    end
    drive(0, 0, 0);
    check("lit_moore_z after10", 32'(z2), 1);
    check("lit_ov_count", cd[0], 3);
    check("lit_nov_count", cd[1], 2);
    check("lit_moore_count", cd[2], 3);
    tick();
    drive(0, 0, 0);
    check("lit_moore_z width", 32'(z2), 0);
    tick();

    // seven 1s: 111 matches on bits 3..7, counter saturates at 3
    drive(0, 0, 1); tick();
    for (int k = 0; k < 7; k++) begin
      drive(1, 1, 0);
      check($sformatf("lit_111_z bit%0d", k + 1), 32'(z3), (k >= 2) ? 1 : 0);
      tick();
    end
    drive(0, 0, 0);
    check("lit_111_count_sat", cd[3], 3);
    tick();

    // en gap keeps the partial match
    drive(0, 0, 1); tick();
    drive(1, 1, 0); tick();
    drive(0, 1, 0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'(k % 2 == 0), 0, 0);
      check($sformatf("lit_gap_s cyc%0d", k), sd[0], 2);
      check($sformatf("lit_gap_z cyc%0d", k), 32'(z0), 0);
      tick();
    end
    drive(1, 1, 0); tick();
    drive(1, 1, 0);
    check("lit_gap_z last", 32'(z0), 1);
    tick();
    drive(0, 0, 0);
    check("lit_gap_count", cd[0], 1);
    tick();

    // reset mid-operation discards 101
    drive(0, 0, 1); tick();
    drive(1, 1, 0); tick();
    drive(0, 1, 0); tick();
    drive(1, 1, 0); tick();
    drive(0, 0, 1);
    check("lit_rst_z", 32'(z0), 0);
    tick();
    drive(1, 1, 0);
    check("lit_rst_z after", 32'(z0), 0);
    tick();
    drive(0, 0, 0);
    check("lit_rst_s", sd[0], 1);
    check("lit_rst_count", cd[0], 0);
    tick();

    // reset coinciding with a completing bit
    drive(0, 0, 1); tick();
    drive(1, 1, 0); tick();
    drive(0, 1, 0); tick();
    drive(1, 1, 0); tick();
    drive(1, 1, 1); tick();
    drive(0, 0, 0);
    check("lit_rstwin_moore_z", 32'(z2), 0);
    check("lit_rstwin_count", cd[2], 0);
    check("lit_rstwin_s", sd[0], 0);
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
